// File: rtl/cmp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_sched_pkg
// Brief    : Opcodes, FSM encoding and widths for the comparator scheduler.
// Revision : 1.0
// ============================================================================
package cmp_sched_pkg;

    localparam int NUM_PORTS = 2;
    localparam int DATA_W    = 32;
    localparam int ID_W      = $clog2(NUM_PORTS);
    localparam int CNT_W     = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_SLT   = 4'd0;
    localparam logic [3:0] OP_SLTU  = 4'd1;
    localparam logic [3:0] OP_SLTI  = 4'd2;
    localparam logic [3:0] OP_SLTIU = 4'd3;
    localparam logic [3:0] OP_CLO   = 4'd4;
    localparam logic [3:0] OP_CLZ   = 4'd5;
    localparam logic [3:0] OP_MOVZ  = 4'd6;
    localparam logic [3:0] OP_GEZ   = 4'd7;
    localparam logic [3:0] OP_EQ    = 4'd8;
    localparam logic [3:0] OP_LTZ   = 4'd9;
    localparam logic [3:0] OP_GTZ   = 4'd10;
    localparam logic [3:0] OP_LEZ   = 4'd11;
    localparam logic [3:0] OP_NEZ   = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_count_op(input logic [3:0] op);
        return (op == OP_CLO) || (op == OP_CLZ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_chunk_scan.sv
`default_nettype none
// ============================================================================
// Module   : cmp_chunk_scan
// Brief    : Counts leading bits (MSB-first) equal to match_i; flags a mismatch.
// Revision : 1.0
// ============================================================================
module cmp_chunk_scan #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  chunk_i,
    input  logic          match_i,
    output logic [CW-1:0] count_o,
    output logic          mismatch_o
);

    always_comb begin
        count_o    = '0;
        mismatch_o = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!mismatch_o) begin
                if (chunk_i[i] == match_i) begin
                    count_o = count_o + CW'(1);
                end else begin
                    mismatch_o = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmp_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmp_sched
// Brief    : Two-port round-robin scheduler for the compare/count datapath.
//            CMP_SCHED_FASTCNT_EN: single-cycle CLO/CLZ via 32-bit encoder.
// Revision : 1.0
// ============================================================================
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter int SCAN_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [3:0]        p0_op,
    input  logic [DATA_W-1:0] p0_a,
    input  logic [DATA_W-1:0] p0_b,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [3:0]        p1_op,
    input  logic [DATA_W-1:0] p1_a,
    input  logic [DATA_W-1:0] p1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              w_grant, w_accept, w_start_scan, w_scan_done;
    logic [3:0]        w_sel_op;
    logic [DATA_W-1:0] w_sel_a, w_sel_b, w_res_data;
    logic              w_res_err;
    logic [CNT_W-1:0]  w_scan_total;

    // prio only arbitrates a tie; a lone requester always wins.
    assign w_grant  = (p0_valid & p1_valid) ? prio_q : p1_valid;
    assign w_accept = (state_q == ST_IDLE) & ~flush & ~reset & (p0_valid | p1_valid);
    assign p0_ready = w_accept & ~w_grant;
    assign p1_ready = w_accept &  w_grant;

    assign w_sel_op = w_grant ? p1_op : p0_op;
    assign w_sel_a  = w_grant ? p1_a  : p0_a;
    assign w_sel_b  = w_grant ? p1_b  : p0_b;

`ifdef CMP_SCHED_FASTCNT_EN
    logic [CNT_W-1:0] w_fast_cnt;
    logic             w_fast_miss;

    cmp_chunk_scan #(.W(DATA_W), .CW(CNT_W)) u_fast (
        .chunk_i    (w_sel_a),
        .match_i    (w_sel_op == OP_CLO),
        .count_o    (w_fast_cnt),
        .mismatch_o (w_fast_miss)
    );

    assign w_start_scan = 1'b0;
    assign w_scan_done  = 1'b1;
    assign w_scan_total = '0;
`else
    localparam int CHUNK_CW = $clog2(SCAN_BITS + 1);

    logic [DATA_W-1:0]   a_q;
    logic                pol_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CHUNK_CW-1:0] w_chunk_cnt;
    logic                w_chunk_miss;

    // The operand shifts left each SCAN cycle so the next chunk is always on top.
    cmp_chunk_scan #(.W(SCAN_BITS), .CW(CHUNK_CW)) u_scan (
        .chunk_i    (a_q[DATA_W-1 -: SCAN_BITS]),
        .match_i    (pol_q),
        .count_o    (w_chunk_cnt),
        .mismatch_o (w_chunk_miss)
    );

    assign w_start_scan = w_accept & is_count_op(w_sel_op);
    assign w_scan_total = cnt_q + CNT_W'(w_chunk_cnt);
    assign w_scan_done  = w_chunk_miss | (w_scan_total == CNT_W'(DATA_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            pol_q <= 1'b0;
            cnt_q <= '0;
        end else if (w_start_scan) begin
            a_q   <= w_sel_a;
            pol_q <= (w_sel_op == OP_CLO);
            cnt_q <= '0;
        end else if (state_q == ST_SCAN) begin
            a_q   <= a_q << SCAN_BITS;
            cnt_q <= w_scan_total;
        end
    end
`endif

    always_comb begin
        w_res_data = '0;
        w_res_err  = 1'b0;
        case (w_sel_op)
            OP_SLT, OP_SLTI:   w_res_data[0] = $signed(w_sel_a) < $signed(w_sel_b);
            OP_SLTU, OP_SLTIU: w_res_data[0] = w_sel_a < w_sel_b;
`ifdef CMP_SCHED_FASTCNT_EN
            OP_CLO, OP_CLZ:    w_res_data = w_fast_miss ? DATA_W'(w_fast_cnt) : DATA_W'(DATA_W);
`else
            OP_CLO, OP_CLZ:    w_res_data = '0;
`endif
            OP_MOVZ:           w_res_data[0] = (w_sel_b == '0);
            OP_GEZ:            w_res_data[0] = ~w_sel_a[DATA_W-1];
            OP_EQ:             w_res_data[0] = (w_sel_a == w_sel_b);
            OP_LTZ:            w_res_data[0] = w_sel_a[DATA_W-1];
            OP_GTZ:            w_res_data[0] = ~w_sel_a[DATA_W-1] & (w_sel_a != '0);
            OP_LEZ:            w_res_data[0] = w_sel_a[DATA_W-1] | (w_sel_a == '0);
            OP_NEZ:            w_res_data[0] = (w_sel_a != '0);
            default:           w_res_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    prio_d = ~w_grant;
                    id_d   = w_grant;
                    if (w_start_scan) begin
                        state_d = ST_SCAN;
                    end else begin
                        data_d  = w_res_data;
                        err_d   = w_res_err;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SCAN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (w_scan_done) begin
                    data_d  = DATA_W'(w_scan_total);
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire
